// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler that time-shares one N-bit ALU
// between two valid/ready requesters and returns a registered result.
module alu_share_sched #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    input  logic [3:0]       req0_f,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    input  logic [3:0]       req1_f,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_y,
    output logic             res_cout,
    output logic             res_ov,
    output logic             res_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t       state, state_nx;
    logic         rr_last;        // port granted most recently
    logic [N-1:0] op_a, op_b;
    logic [3:0]   op_f;
    logic         op_id;

    logic         grant_any, grant_id;
    logic         accept, deliver;

    logic [N-1:0] bop, logic_y, alu_y;
    logic [N:0]   sum;
    logic         carry, sov, slt, alu_ov;

    // Round-robin arbitration: a lone requester wins, otherwise the port not served last
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_last;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Next-state and handshake decode; readies are only offered in IDLE and never during reset
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        deliver    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset && grant_any) begin
                    accept     = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nx   = EXEC;
                end
            end
            EXEC: state_nx = DONE;
            DONE: begin
                if (res_valid && res_ready) begin
                    deliver  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shared ALU on the latched operands; flags come from the adder for every code
    always_comb begin
        bop    = op_f[1] ? ~op_b : op_b;
        sum    = {1'b0, op_a} + {1'b0, bop} + {{N{1'b0}}, op_f[1]};
        carry  = sum[N];
        sov    = (op_a[N-1] == bop[N-1]) && (sum[N-1] != op_a[N-1]);
        slt    = op_f[0] ? ~carry : (sum[N-1] ^ sov);
        alu_ov = op_f[0] ? (op_f[1] ^ carry) : sov;
        logic_y = '0;
        case (op_f[1:0])
            2'b00: logic_y = op_a & op_b;
            2'b01: logic_y = op_a | op_b;
            2'b10: logic_y = op_a ^ op_b;
            2'b11: logic_y = ~(op_a | op_b);
            default: logic_y = '0;
        endcase
        if (op_f[2]) begin
            alu_y = logic_y;
        end else if (op_f[3]) begin
            alu_y = {{(N-1){1'b0}}, slt};
        end else begin
            alu_y = sum[N-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Operand latch, RR pointer, result register and delivered-result counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last   <= 1'b1;
            op_a      <= '0;
            op_b      <= '0;
            op_f      <= '0;
            op_id     <= 1'b0;
            res_valid <= 1'b0;
            res_y     <= '0;
            res_cout  <= 1'b0;
            res_ov    <= 1'b0;
            res_id    <= 1'b0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                rr_last <= grant_id;
                op_id   <= grant_id;
                op_a    <= grant_id ? req1_a : req0_a;
                op_b    <= grant_id ? req1_b : req0_b;
                op_f    <= grant_id ? req1_f : req0_f;
            end
            if (state == EXEC) begin
                res_valid <= 1'b1;
                res_y     <= alu_y;
                res_cout  <= carry;
                res_ov    <= alu_ov;
                res_id    <= op_id;
            end
            if (deliver) begin
                res_valid <= 1'b0;
                op_count  <= op_count + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// Self-checking bench for alu_share_sched: vector table plus directed multi-cycle sequences.
module tb_alu_share_sched;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_f, req1_f;
    logic             req0_ready, req1_ready;
    logic             res_valid, res_ready;
    logic [N-1:0]     res_y;
    logic             res_cout, res_ov, res_id, busy;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    alu_share_sched #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
        .res_cout(res_cout), .res_ov(res_ov), .res_id(res_id),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic [3:0] a, b, f, y;
        logic       c, ov;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        step();
        step();
        reset   = 1'b0;
        exp_cnt = 0;
        #1;
    endtask

    // Offer one op on port p, wait (bounded) for ready, return just after the accept edge
    task automatic issue(input logic p, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] f);
        int unsigned k;
        k = 0;
        if (p) begin
            req1_a = a; req1_b = b; req1_f = f; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_f = f; req0_valid = 1'b1;
        end
        #1;
        while (!(p ? req1_ready : req0_ready) && k < 20) begin
            step();
            k++;
        end
        check("accept_timeout", (k < 20), 1);
        step();
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    initial begin : main
        int gcyc[$];
        int gid[$];
        int rid[$];
        logic both_seen;
        int unsigned k;
        logic [3:0] held_y;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_f = '0;
        req1_a = '0; req1_b = '0; req1_f = '0;

        //             p     a      b      f        y      c     ov
        tbl[0]  = '{1'b0, 4'h5, 4'h3, 4'b0000, 4'h8, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 4'h3, 4'h5, 4'b0010, 4'hE, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'h3, 4'h5, 4'b1010, 4'h1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'h3, 4'h5, 4'b1011, 4'h1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'hC, 4'hA, 4'b0100, 4'h8, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 4'hC, 4'hA, 4'b0101, 4'hE, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'hC, 4'hA, 4'b0110, 4'h6, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 4'hC, 4'hA, 4'b0111, 4'h1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 4'h1, 4'b0001, 4'h0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 4'h7, 4'h8, 4'b1010, 4'h0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'h7, 4'h8, 4'b1011, 4'h1, 1'b0, 1'b1};

        // Reset values
        step();
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_busy", busy, 0);
        step();
        reset = 1'b0;
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_y", res_y, 0);
        check("rst_res_cout", res_cout, 0);
        check("rst_res_ov", res_ov, 0);
        check("rst_res_id", res_id, 0);
        check("rst_op_count", op_count, 0);

        // Reset during EXEC discards the op; readies stay low while reset is held
        issue(1'b0, 4'h5, 4'h3, 4'b0000);
        check("exec_busy", busy, 1);
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rexec_busy", busy, 0);
        check("rexec_res_valid", res_valid, 0);
        check("rexec_op_count", op_count, 0);
        check("rexec_ready0", req0_ready, 0);
        check("rexec_ready1", req1_ready, 0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_grant0", req0_ready, 1);
        check("post_rst_not1", req1_ready, 0);
        do_reset();

        // Vector table: one op per entry with full handshake
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].f);
            check($sformatf("busy_exec[%0d]", i), busy, 1);
            check($sformatf("rv_exec[%0d]", i), res_valid, 0);
            step();
            check($sformatf("rv[%0d]", i), res_valid, 1);
            check($sformatf("y[%0d]", i), res_y, tbl[i].y);
            check($sformatf("cout[%0d]", i), res_cout, tbl[i].c);
            check($sformatf("ov[%0d]", i), res_ov, tbl[i].ov);
            check($sformatf("id[%0d]", i), res_id, tbl[i].p);
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            exp_cnt++;
            check($sformatf("cnt[%0d]", i), op_count, exp_cnt);
            check($sformatf("rv_clr[%0d]", i), res_valid, 0);
            check($sformatf("idle[%0d]", i), busy, 0);
            check($sformatf("y_hold[%0d]", i), res_y, tbl[i].y);
        end

        // Reset while a result waits in DONE
        issue(1'b1, 4'hC, 4'hA, 4'b0101);
        step();
        check("done_rv", res_valid, 1);
        reset = 1'b1;
        #1;
        check("rdone_rv", res_valid, 0);
        check("rdone_y", res_y, 0);
        check("rdone_cout", res_cout, 0);
        check("rdone_ov", res_ov, 0);
        check("rdone_id", res_id, 0);
        check("rdone_cnt", op_count, 0);
        do_reset();

        // Contention: both valid continuously, results drained immediately
        req0_a = 4'h1; req0_b = 4'h1; req0_f = 4'b0000;
        req1_a = 4'h2; req1_b = 4'h2; req1_f = 4'b0000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b1;
        both_seen  = 1'b0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (req0_ready && req1_ready) both_seen = 1'b1;
            if (req0_ready) begin gcyc.push_back(c); gid.push_back(0); end
            if (req1_ready) begin gcyc.push_back(c); gid.push_back(1); end
            if (res_valid) rid.push_back(int'(res_id));
            step();
        end
        check("both_ready", both_seen, 0);
        check("grant_count", gid.size(), 4);
        check("resid_count", rid.size(), 4);
        if (gid.size() >= 4 && rid.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("grant_id[%0d]", i), gid[i], i % 2);
                check($sformatf("res_id_seq[%0d]", i), rid[i], i % 2);
                if (i > 0) check($sformatf("grant_gap[%0d]", i), gcyc[i] - gcyc[i-1], 3);
            end
        end
        do_reset();

        // Backpressure: result held in DONE for 5 cycles while port 1 waits
        issue(1'b0, 4'h6, 4'h1, 4'b0000);
        step();
        check("bp_rv", res_valid, 1);
        check("bp_y", res_y, 4'h7);
        held_y = res_y;
        req1_a = 4'h2; req1_b = 4'h3; req1_f = 4'b0000;
        req1_valid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold_rv[%0d]", c), res_valid, 1);
            check($sformatf("bp_hold_y[%0d]", c), res_y, held_y);
            check($sformatf("bp_hold_id[%0d]", c), res_id, 0);
            check($sformatf("bp_busy[%0d]", c), busy, 1);
            check($sformatf("bp_rdy[%0d]", c), {req0_ready, req1_ready}, 0);
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp_rv_clr", res_valid, 0);
        check("bp_cnt", op_count, 1);
        check("bp_next_ready", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        check("bp_next_busy", busy, 1);
        step();
        check("bp_next_rv", res_valid, 1);
        check("bp_next_y", res_y, 4'h5);
        check("bp_next_id", res_id, 1);
        do_reset();

        // Counter wrap: 256 delivered results bring op_count back to 0
        req0_a = 4'h1; req0_b = 4'h1; req0_f = 4'b0000;
        req0_valid = 1'b1;
        res_ready  = 1'b1;
        k = 0;
        while (op_count != 8'd255 && k < 2000) begin
            step();
            k++;
        end
        check("wrap_reach_255", (k < 2000), 1);
        check("wrap_255", op_count, 255);
        k = 0;
        while (!res_valid && k < 10) begin
            step();
            k++;
        end
        check("wrap_rv_timeout", (k < 10), 1);
        step();
        check("wrap_zero", op_count, 0);
        req0_valid = 1'b0;
        res_ready  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_sched.md
# alu_share_sched

Two-port scheduler that time-shares one N-bit ALU between two requesters. Each requester offers an operation (A, B, 4-bit function code) through a valid/ready handshake. The block arbitrates round-robin, latches the winner's operands, and drives them through a single internal ALU instance. It returns one registered result (Y, carry, overflow, requester ID) through a valid/ready result port. It sits between the switch/keypad capture logic and the display/readback logic, replacing direct wiring of switches to the ALU.

## Interface
- N, 4, operand and result width (≥2)
- CNT_W, 8, width of completed-operation counter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid  in  1  port 0 offers an operation
- req0_a, req0_b  in  N  port 0 operands
- req0_f  in  4  port 0 function code
- req0_ready  out  1  port 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_f, req1_ready  same as port 0, for port 1
- res_valid  out  1  result register holds an undelivered result
- res_ready  in  1  consumer accepts result
- res_y  out  N  ALU result
- res_cout  out  1  adder carry-out
- res_ov  out  1  overflow flag
- res_id  out  1  requester that issued this result (0/1)
- busy  out  1  state ≠ IDLE
- op_count  out  CNT_W  number of results delivered, wraps

## Operation
- Internal ALU function encoding (all 16 codes legal):
  - F[2]=1 selects logic op on F[1:0]: 00 AND, 01 OR, 10 XOR, 11 NOR.
  - F[2]=0, F[3]=0 selects add (F[1]=0) or subtract (F[1]=1, computed as A+~B+1).
  - F[2]=0, F[3]=1 selects set-less-than, result zero-extended to N bits. F[0]=1 is unsigned (Y=~carry). F[0]=0 is signed (sign of sum, corrected by signed overflow).
- Flags for every code:
  - res_cout = carry of A+(F[1]?~B:B)+F[1].
  - res_ov = F[0] ? (F[1]^carry) : signed overflow of that sum.
- FSM states:
  - IDLE: reqX_ready is driven combinationally for the granted port only. A transfer is reqX_valid && reqX_ready. On transfer, latch A/B/F/ID, update the RR pointer, go to EXEC. With no valid request, stay in IDLE.
  - EXEC: one cycle. The ALU evaluates the latched operands. At the clock edge, load res_y/res_cout/res_ov/res_id and set res_valid=1. Go to DONE.
  - DONE: hold res_* stable. On res_valid && res_ready: clear res_valid, op_count += 1 (mod 2^CNT_W), go to IDLE.
- Arbitration:
  - Only one valid request: grant it.
  - Both valid: grant the port not granted last.
  - The RR pointer changes only on an accepted transfer. After reset it favours port 0.
- req0_ready and req1_ready are never both 1. Both are 0 outside IDLE and while reset is asserted.
- A requester holds valid and operands stable until ready. Deasserting valid before ready is allowed and simply withdraws the request.
- res_y/res_cout/res_ov/res_id hold their last values after handshake until the next EXEC.

## Timing
- Reset values: state IDLE, res_valid 0, res_y 0, res_cout 0, res_ov 0, res_id 0, op_count 0, busy 0, RR pointer = port 1 last granted.
- Accept at edge E0, then res_valid=1 after E1 (latency 1 cycle from acceptance edge).
- Earliest result handshake is at E1's following edge E2. The next accept is at E3. Peak throughput is 1 op per 3 cycles.
- res_ready held low: stay in DONE indefinitely, with both reqX_ready low.
- res_ready high in DONE and a new request valid in the same cycle: only the result handshake occurs. The request is granted in the following IDLE cycle.
- Reset asserted in EXEC or DONE: immediately return to reset values. The in-flight operation is discarded and not counted.
- op_count wrap: 2^CNT_W−1 → 0 on the next delivered result.

## Test plan
- Add, N=4: port0 A=5, B=3, F=0000 → one cycle after accept, res_y=8, res_cout=0, res_ov=1, res_id=0, op_count 0→1 after handshake.
- Subtract and signed SLT: port1 A=3, B=5.
  - F=0010 → res_y=0xE, cout=0, ov=0, id=1.
  - F=1010 → res_y=0x1.
  - F=1011 (unsigned) → res_y=0x1.
- Logic ops: A=0xC, B=0xA.
  - F=0100 → res_y=0x8.
  - F=0101 → 0xE.
  - F=0110 → 0x6.
  - F=0111 → 0x1.
- Contention: both ports valid continuously from the first cycle after reset, res_ready=1 → grants alternate 0,1,0,1. Each grant is 3 cycles apart, req0_ready and req1_ready are never simultaneous, and res_id sequence is 0,1,0,1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid and res_* remain stable, busy=1, no reqX_ready. Raise res_ready → the handshake occurs and the next request is accepted 1 cycle later.
- Reset mid-op and wrap: assert reset during EXEC → all outputs return to reset values asynchronously and op_count stays unchanged at 0. Separately, deliver 256 results with CNT_W=8 → op_count returns to 0.
